adder_result_accumulator: RTL and testbench
===========================================

Name: adder_result_accumulator

Overview:
- Downstream consumer of the 4-bit adder stage; takes each {cout, sum} result as a 5-bit sample (0..31).
- Accumulates a fixed number of samples into an ACC_W-bit running total, then presents the total plus an overflow flag on a valid/ready output.
- Sits between the adder datapath and lab display/checker logic; converts a per-cycle result stream into one frame total.

Parameters:
ACC_W, 8, accumulator/output width in bits; legal range ACC_W >= 5
SAMPLES, 16, samples per frame; legal range SAMPLES >= 1; counter width is $clog2(SAMPLES+1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous frame abort/clear, active-high
in_valid  input  1  adder result valid
in_ready  output  1  accumulator can accept a sample
in_sum  input  4  adder sum bits
in_cout  input  1  adder carry-out
out_valid  output  1  frame total available
out_ready  input  1  downstream accepts total
out_total  output  ACC_W  accumulated frame total
out_ovf  output  1  frame total exceeded 2^ACC_W-1
out_count  output  $clog2(SAMPLES+1)  samples accepted in current frame

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; acc=0, count=0, ovf=0; in_ready=0 while rst_n=0, then 1 from the first clock after release; out_valid=0; out_total=0; out_ovf=0; out_count=0.
- Sample value = {in_cout, in_sum}, zero-extended to ACC_W+1 bits. Accept = in_valid & in_ready.
- FSM:
  - IDLE: in_ready=1. On accept: acc=sample, count=1, ovf=0. Next state is DONE if SAMPLES==1, else ACCUM.
  - ACCUM: in_ready=1. On accept: sum = acc + sample in ACC_W+1 bits; acc=sum[ACC_W-1:0]; ovf |= sum[ACC_W] (sticky); count++. When count reaches SAMPLES, next state is DONE.
  - DONE: in_ready=0; out_valid=1; out_total=acc; out_ovf=ovf. Outputs hold stable while out_ready=0. On out_valid & out_ready: next state IDLE; acc, count and ovf cleared.
- Latency: out_valid rises on the clock edge that accepts the final sample, i.e. it is visible in the cycle after the last accept.
- No-input cycles (in_valid=0) in IDLE or ACCUM: no change to any register.
- in_valid while in DONE: ignored, because in_ready=0. An upstream sample presented in the handshake cycle is not accepted; it is accepted one cycle later, in IDLE.
- clr=1: highest priority after reset. Next state IDLE; acc, count, ovf cleared; out_valid dropped, even mid-handshake. A sample presented with clr=1 is discarded.
- out_total and out_ovf equal the live acc and ovf in every state. They are only meaningful while out_valid=1.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from state only.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: on an add with sum[ACC_W]=1, acc saturates to all-ones and stays at all-ones for the rest of the frame. ovf is still set sticky.
- Undefined: acc wraps modulo 2^ACC_W and ovf is set sticky.
- All handshake and FSM behaviour is identical in both builds.

Test Plan:
- Reset release, then 16 samples k=0..15 ({cout,sum}=k), one per cycle, out_ready=1 -> out_valid for exactly 1 cycle, asserted 1 cycle after the 16th accept; out_total=0x78 (120); out_ovf=0.
- 16 samples of cout=1, sum=0xF (31 each) -> total 496. Without ACC_SAT_EN: out_total=0xF0, out_ovf=1. With ACC_SAT_EN: out_total=0xFF, out_ovf=1.
- Frame of k=1..16 (values 1..16, sum 136) with out_ready=0 for 5 cycles and in_valid held 1 -> out_valid and out_total=0x88 stable for 5 cycles; in_ready=0 throughout; no extra sample absorbed; next frame starts the cycle after out_ready=1.
- Gapped input: in_valid toggling 1,0,0,1,... over 16 valid samples of value 2 -> out_total=0x20; out_count holds during gaps.
- clr=1 after 7 samples of value 5 -> state IDLE next cycle; out_count=0; the following 16 samples of value 1 give out_total=0x10, not 0x33.
- rst_n driven low asynchronously mid-ACCUM and mid-DONE (between clock edges) -> all outputs return to reset values immediately without a clock edge; clean frame afterwards.

Source files
------------

// File: rtl/adder_result_accumulator_if.sv
// rtl/adder_result_accumulator_if.sv - sample-in / frame-total-out handshake bundle for the accumulator
interface adder_result_accumulator_if #(
  parameter int ACC_W   = 8,
  parameter int SAMPLES = 16
);
  localparam int CW = $clog2(SAMPLES + 1);

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             out_ovf;
  logic [CW-1:0]    out_count;

  modport master (
    output clr, in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_total, out_ovf, out_count
  );

  modport slave (
    input  clr, in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_total, out_ovf, out_count
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - sums SAMPLES adder results into one frame total with sticky overflow
// Define ACC_SAT_EN to saturate the total at all-ones instead of wrapping.
module adder_result_accumulator #(
  parameter int ACC_W   = 8,
  parameter int SAMPLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adder_result_accumulator_if.slave   bus
);
  localparam int CW = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic [ACC_W:0]   w_sample;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CW-1:0]    w_count_inc;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_sample    = {{(ACC_W-4){1'b0}}, bus.in_cout, bus.in_sum};
  assign w_sum       = {1'b0, r_acc} + w_sample;
  assign w_count_inc = r_count + CW'(1);

`ifdef ACC_SAT_EN
  // Once saturated, any further non-zero add carries out again and re-clamps.
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // in_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_sample[ACC_W-1:0];
            r_ovf   <= 1'b0;
            r_count <= CW'(1);
            if (SAMPLES == 1) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_ovf   <= r_ovf | w_sum[ACC_W];
            r_count <= w_count_inc;
            if (w_count_inc == CW'(SAMPLES)) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (r_out_valid && bus.out_ready) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_total = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb/tb_adder_result_accumulator.sv - directed frames against a frame-sum model of the accumulator
module tb_adder_result_accumulator;
  localparam int ACC_W   = 8;
  localparam int SAMPLES = 16;
  localparam int MAXV    = (1 << ACC_W) - 1;

  logic clk;
  logic rst_n;

  adder_result_accumulator_if #(.ACC_W(ACC_W), .SAMPLES(SAMPLES)) bus ();

  adder_result_accumulator #(.ACC_W(ACC_W), .SAMPLES(SAMPLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Frame model: true integer sum of accepted samples, how many, and whether a total is on offer.
  bit m_rdy;
  bit m_full;
  int m_count;
  int m_sum;

  function automatic int exp_total(input int s);
`ifdef ACC_SAT_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy   <= 1'b0;
      m_full  <= 1'b0;
      m_count <= 0;
      m_sum   <= 0;
    end else if (bus.clr) begin
      m_rdy   <= 1'b1;
      m_full  <= 1'b0;
      m_count <= 0;
      m_sum   <= 0;
    end else if (m_full) begin
      if (bus.out_ready) begin
        m_full  <= 1'b0;
        m_rdy   <= 1'b1;
        m_count <= 0;
        m_sum   <= 0;
      end
    end else begin
      m_rdy <= 1'b1;
      if (bus.in_valid && m_rdy) begin
        m_sum   <= m_sum + int'({bus.in_cout, bus.in_sum});
        m_count <= m_count + 1;
        if (m_count + 1 == SAMPLES) begin
          m_full <= 1'b1;
          m_rdy  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(bus.in_ready), int'(m_rdy));
      chk("out_valid", int'(bus.out_valid), int'(m_full));
      chk("out_count", int'(bus.out_count), m_count);
      if (m_full) begin
        chk("out_total", int'(bus.out_total), exp_total(m_sum));
        chk("out_ovf", int'(bus.out_ovf), int'(m_sum > MAXV));
      end
    end
  end

  task automatic cyc(input bit v, input int val, input bit ordy, input bit c);
    bus.in_valid  = v;
    bus.in_cout   = val[4];
    bus.in_sum    = val[3:0];
    bus.out_ready = ordy;
    bus.clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_chk(input string name, input int total, input int ovf);
    chk({name, " valid"}, int'(bus.out_valid), 1);
    chk({name, " total"}, int'(bus.out_total), total);
    chk({name, " ovf"}, int'(bus.out_ovf), ovf);
  endtask

  task automatic reset_chk(input string name);
    chk({name, " in_ready"}, int'(bus.in_ready), 0);
    chk({name, " out_valid"}, int'(bus.out_valid), 0);
    chk({name, " out_total"}, int'(bus.out_total), 0);
    chk({name, " out_ovf"}, int'(bus.out_ovf), 0);
    chk({name, " out_count"}, int'(bus.out_count), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_cout   = 1'b0;
    bus.in_sum    = 4'd0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_chk("reset");
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    chk("ready after release", int'(bus.in_ready), 1);

    // k = 0..15 -> 120
    for (int k = 0; k < 16; k++) cyc(1, k, 1, 0);
    frame_chk("ramp", 120, 0);
    cyc(0, 0, 1, 0);
    chk("ramp single beat", int'(bus.out_valid), 0);

    // 16 x 31 = 496
    for (int k = 0; k < 16; k++) cyc(1, 31, 1, 0);
`ifdef ACC_SAT_EN
    frame_chk("max", 255, 1);
`else
    frame_chk("max", 240, 1);
`endif
    cyc(0, 0, 1, 0);

    // 1..16 = 136 held under back-pressure with in_valid still high
    for (int k = 1; k <= 16; k++) cyc(1, k, 0, 0);
    for (int i = 0; i < 5; i++) begin
      frame_chk("hold", 136, 0);
      chk("hold in_ready", int'(bus.in_ready), 0);
      cyc(1, 5, 0, 0);
    end
    cyc(1, 5, 1, 0);
    chk("handshake drop", int'(bus.out_valid), 0);
    chk("handshake count", int'(bus.out_count), 0);
    for (int i = 0; i < 7; i++) cyc(1, 5, 1, 0);
    chk("pre-clr count", int'(bus.out_count), 7);
    cyc(1, 5, 1, 1);
    chk("clr count", int'(bus.out_count), 0);
    chk("clr ready", int'(bus.in_ready), 1);
    for (int k = 0; k < 16; k++) cyc(1, 1, 1, 0);
    frame_chk("after clr", 16, 0);
    cyc(0, 0, 1, 0);

    // gapped valid pattern 1,0,0
    for (int i = 0; i < 16; i++) begin
      cyc(1, 2, 1, 0);
      if (i < 15) begin
        cyc(0, 2, 1, 0);
        cyc(0, 2, 1, 0);
      end
    end
    frame_chk("gapped", 32, 0);
    cyc(0, 0, 1, 0);

    // asynchronous reset mid-accumulate
    for (int i = 0; i < 5; i++) cyc(1, 3, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_chk("async accum");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);

    // asynchronous reset while a total is waiting
    for (int k = 0; k < 16; k++) cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    frame_chk("pre-reset done", 32, 0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_chk("async done");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);

    for (int k = 0; k < 16; k++) cyc(1, k, 1, 0);
    frame_chk("clean", 120, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
